wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RETIRE_W, default 32, width of retire counter; used only when WB_RETIRE_CNT_EN is defined.
REQ-002 clk  input  1  pipeline clock; WB register updates on rising edge.
REQ-003 rst  input  1  reset rst, asynchronous, active-high.
REQ-004 stall  input  1  hold WB register contents.
REQ-005 flush  input  1  invalidate WB register; has priority over stall.
REQ-006 mem_valid  input  1  MEM-stage slot holds a real instruction.
REQ-007 mem_regwrite  input  1  instruction writes a register.
REQ-008 mem_rd  input  5  destination register index.
REQ-009 mem_wdsel  input  2  write-data source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-010 mem_funct3  input  3  load type.
REQ-011 mem_alu_res  input  32  ALU result / load byte address.
REQ-012 mem_rdata  input  32  raw aligned data-memory word.
REQ-013 mem_pc4  input  32  PC+4 of instruction.
REQ-014 wb_valid  output  1  WB slot valid.
REQ-015 wb_rfwr  output  1  register-file write enable.
REQ-016 wb_rd  output  5  register-file write index.
REQ-017 wb_wd  output  32  register-file write data.
REQ-018 retire_cnt  output  RETIRE_W  retired-instruction count (present only with WB_RETIRE_CNT_EN).

Function
REQ-019 The block SHALL hold one MEM/WB register capturing all mem_* inputs on the rising clk edge.
REQ-020 Edge priority SHALL be: flush -> valid cleared, other fields don't-care; else stall -> all fields held; else all fields loaded from mem_*.
REQ-021 Latency SHALL be one cycle: inputs captured at edge N appear on wb_* after edge N.
REQ-022 wb_rfwr SHALL equal valid AND regwrite AND (rd != 0), combinational from registered fields.
REQ-023 wb_rd SHALL equal the registered rd; wb_valid the registered valid.
REQ-024 wb_wd SHALL be combinational: wdsel 00 -> alu_res; 01 -> load-extended data; 10 -> pc4; 11 -> 0.
REQ-025 Load extraction SHALL use registered alu_res[1:0]: byte = rdata[8*a+7:8*a]; halfword = rdata[16*a[1]+15:16*a[1]], a[0] ignored.
REQ-026 funct3 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011/110/111 full word.
REQ-027 Stall and flush asserted together SHALL flush.
REQ-028 While stalled, wb_rfwr SHALL remain asserted if the held instruction writes; downstream write is idempotent.

Reset
REQ-029 rst high SHALL immediately clear valid, regwrite, rd, wdsel, funct3, alu_res, rdata, pc4 to 0, forcing wb_rfwr=0, wb_wd=0.
REQ-030 rst asserted mid-stall or mid-flush SHALL override both; first capture occurs on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro WB_RETIRE_CNT_EN defined: retire_cnt port exists; counter increments by 1 on each rising edge where flush=0, stall=0 and mem_valid=1; wraps modulo 2^RETIRE_W; resets to 0 asynchronously.
REQ-032 Macro WB_RETIRE_CNT_EN undefined: retire_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset: rst=1 mid-cycle with loaded register -> wb_valid=0, wb_rfwr=0, wb_wd=0 immediately; retire_cnt=0.
REQ-034 Loads: rdata=0x80F0_7F81, wdsel=01; LB addr..1 -> 0x0000007F; LB addr..0 -> 0xFFFFFF81; LBU addr..3 -> 0x00000080; LH addr..2 -> 0xFFFF80F0; LHU addr..0 -> 0x00007F81; LW -> 0x80F07F81.
REQ-035 Sources: alu_res=0x1234, pc4=0x0000_0044; wdsel 00 -> 0x1234, 10 -> 0x44, 11 -> 0 one cycle later.
REQ-036 x0 guard: valid=1, regwrite=1, rd=0 -> wb_rfwr=0; rd=5 -> wb_rfwr=1, wb_rd=5.
REQ-037 Stall/flush: load rd=7, then stall 3 cycles with changing inputs -> wb_rd stays 7; stall+flush together -> wb_valid=0 next cycle; retire_cnt counts only unstalled unflushed valid captures.
REQ-038 Counter wrap (RETIRE_W=4, macro defined): 17 valid captures -> retire_cnt=1.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with register-file write-back data selection and load extension.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wdsel,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc4,
    output logic        wb_valid,
    output logic        wb_rfwr,
    output logic [4:0]  wb_rd,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] wb_wd,
    output logic [RETIRE_W-1:0] retire_cnt
`else
    output logic [31:0] wb_wd
`endif
);

    logic        vld_p1;
    logic        regwrite_p1;
    logic [4:0]  rd_p1;
    logic [1:0]  wdsel_p1;
    logic [2:0]  funct3_p1;
    logic [31:0] alu_res_p1;
    logic [31:0] rdata_p1;
    logic [31:0] pc4_p1;

    // Select the addressed byte/halfword of the aligned word and extend it per load type.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  addr,
                                                input logic [31:0] word);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [31:0] res;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = 32'(signed'(b));
            3'b001:  res = 32'(signed'(h));
            3'b100:  res = signed'({24'd0, b});
            3'b101:  res = signed'({16'd0, h});
            default: res = signed'(word);
        endcase
        return unsigned'(res);
    endfunction

    // ---- MEM -> WB boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            rd_p1       <= '0;
            wdsel_p1    <= '0;
            funct3_p1   <= '0;
            alu_res_p1  <= '0;
            rdata_p1    <= '0;
            pc4_p1      <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1      <= mem_valid;
            regwrite_p1 <= mem_regwrite;
            rd_p1       <= mem_rd;
            wdsel_p1    <= mem_wdsel;
            funct3_p1   <= mem_funct3;
            alu_res_p1  <= mem_alu_res;
            rdata_p1    <= mem_rdata;
            pc4_p1      <= mem_pc4;
        end
    end

    // ---- WB outputs (combinational from the held slot) ----
    always_comb begin
        wb_valid = vld_p1;
        wb_rd    = rd_p1;
        wb_rfwr  = vld_p1 && regwrite_p1 && (rd_p1 != 5'd0);
        case (wdsel_p1)
            2'b00:   wb_wd = alu_res_p1;
            2'b01:   wb_wd = load_extend(funct3_p1, alu_res_p1[1:0], rdata_p1);
            2'b10:   wb_wd = pc4_p1;
            default: wb_wd = 32'd0;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= '0;
        else if (!flush && !stall && mem_valid)
            retire_cnt <= retire_cnt + 1'b1;
    end
`else
    logic [RETIRE_W-1:0] retire_unused;
    assign retire_unused = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal cases plus randomized traffic vs. a behavioural model.
`timescale 1ns/1ps
module tb_wb_stage;
    localparam int RW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wdsel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_res, mem_rdata, mem_pc4;
    logic        wb_valid, wb_rfwr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
`ifdef WB_RETIRE_CNT_EN
    logic [RW-1:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    wb_stage #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wdsel(mem_wdsel), .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
        .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
        .wb_valid(wb_valid), .wb_rfwr(wb_rfwr), .wb_rd(wb_rd),
`ifdef WB_RETIRE_CNT_EN
        .wb_wd(wb_wd), .retire_cnt(retire_cnt)
`else
        .wb_wd(wb_wd)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: the instruction currently in WB, plus an integer retire count.
    bit          m_valid, m_rw;
    int unsigned m_rd, m_sel, m_f3, m_alu, m_rdata, m_pc4;
    int unsigned m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_rw <= 0; m_rd <= 0; m_sel <= 0; m_f3 <= 0;
            m_alu <= 0; m_rdata <= 0; m_pc4 <= 0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 0;
        end else if (!stall) begin
            m_valid <= mem_valid; m_rw <= mem_regwrite; m_rd <= mem_rd;
            m_sel <= mem_wdsel; m_f3 <= mem_funct3; m_alu <= mem_alu_res;
            m_rdata <= mem_rdata; m_pc4 <= mem_pc4;
            if (mem_valid) m_cnt <= (m_cnt + 1) % (1 << RW);
        end
    end

    function automatic int unsigned exp_wd();
        int unsigned a, bt, hf;
        a  = m_alu % 4;
        bt = (m_rdata >> (8 * a)) & 32'hFF;
        hf = (m_rdata >> (16 * (a / 2))) & 32'hFFFF;
        case (m_sel)
            0: return m_alu;
            2: return m_pc4;
            3: return 0;
            default:
                case (m_f3)
                    0: return (bt >= 128) ? bt + 32'hFFFFFF00 : bt;
                    1: return (hf >= 32768) ? hf + 32'hFFFF0000 : hf;
                    4: return bt;
                    5: return hf;
                    default: return m_rdata;
                endcase
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("m_valid", 32'(wb_valid), 32'(m_valid));
            check("m_rfwr", 32'(wb_rfwr), 32'(m_valid && m_rw && m_rd != 0));
            if (m_valid) begin
                check("m_rd", 32'(wb_rd), m_rd);
                check("m_wd", wb_wd, exp_wd());
            end
`ifdef WB_RETIRE_CNT_EN
            check("m_cnt", 32'(retire_cnt), m_cnt);
`endif
        end
    end

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc4);
        mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wdsel = sel;
        mem_funct3 = f3; mem_alu_res = alu; mem_rdata = rdat; mem_pc4 = pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [2:0] f3; logic [1:0] a; logic [31:0] exp; string nm; } ld_t;
    ld_t lds[6];

    initial begin
`ifdef WB_RETIRE_CNT_EN
        logic [RW-1:0] c0;
`endif
        rst = 1'b1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_valid", 32'(wb_valid), 0);
        check("rst_wd", wb_wd, 0);
        step(); step();
        rst = 1'b0;
        cmp_en = 1'b1;

        lds[0] = '{3'b000, 2'd1, 32'h0000007F, "lb1"};
        lds[1] = '{3'b000, 2'd0, 32'hFFFFFF81, "lb0"};
        lds[2] = '{3'b100, 2'd3, 32'h00000080, "lbu3"};
        lds[3] = '{3'b001, 2'd2, 32'hFFFF80F0, "lh2"};
        lds[4] = '{3'b101, 2'd0, 32'h00007F81, "lhu0"};
        lds[5] = '{3'b010, 2'd0, 32'h80F07F81, "lw"};
        foreach (lds[i]) begin
            drive(1, 1, 5'd3, 2'b01, lds[i].f3, {28'h0000100, 2'b00, lds[i].a}, 32'h80F07F81, 32'h4);
            step();
            check(lds[i].nm, wb_wd, lds[i].exp);
        end

        drive(1, 1, 5'd4, 2'b00, 3'b010, 32'h1234, 32'hDEADBEEF, 32'h44);
        step(); check("src_alu", wb_wd, 32'h1234);
        mem_wdsel = 2'b10;
        step(); check("src_pc4", wb_wd, 32'h44);
        mem_wdsel = 2'b11;
        step(); check("src_rsv", wb_wd, 32'h0);

        drive(1, 1, 5'd0, 2'b00, 3'b010, 32'h55, 0, 0);
        step(); check("x0_rfwr", 32'(wb_rfwr), 0);
        mem_rd = 5'd5;
        step(); check("rd5_rfwr", 32'(wb_rfwr), 1); check("rd5_rd", 32'(wb_rd), 5);

        drive(1, 1, 5'd7, 2'b00, 3'b010, 32'h77, 0, 0);
        step();
`ifdef WB_RETIRE_CNT_EN
        c0 = retire_cnt;
`endif
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(9 + i), 2'b00, 3'b010, 32'(i), 0, 0);
            step();
            check("stall_rd", 32'(wb_rd), 7);
            check("stall_rfwr", 32'(wb_rfwr), 1);
            check("stall_wd", wb_wd, 32'h77);
        end
        flush = 1'b1;
        step(); check("sf_valid", 32'(wb_valid), 0);
`ifdef WB_RETIRE_CNT_EN
        check("sf_cnt", 32'(retire_cnt), 32'(c0));
`endif
        stall = 0; flush = 0;

        // Asynchronous reset mid-cycle while stalled with a loaded slot.
        drive(1, 1, 5'd6, 2'b00, 3'b010, 32'hABCD, 0, 0);
        step();
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(wb_valid), 0);
        check("arst_rfwr", 32'(wb_rfwr), 0);
        check("arst_wd", wb_wd, 0);
`ifdef WB_RETIRE_CNT_EN
        check("arst_cnt", 32'(retire_cnt), 0);
`endif
        step();
        rst = 1'b0; stall = 1'b0;
        step();
        check("post_rst_rd", 32'(wb_rd), 6);
        check("post_rst_valid", 32'(wb_valid), 1);

`ifdef WB_RETIRE_CNT_EN
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check("wrap_cnt", 32'(retire_cnt), 1);
`endif

        // Randomized traffic, including occasional reset pulses between edges.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
                  3'($urandom), $urandom, $urandom, $urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1; #1; rst = 1'b0;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
